// File: rtl/dm_pkg.sv
// Shared definitions for the byte-enabled data memory: size encodings, FSM states
// and the byte-enable helper.
package dm_pkg;

    localparam logic [1:0] DM_BYTE = 2'b00;
    localparam logic [1:0] DM_HALF = 2'b01;
    localparam logic [1:0] DM_WORD = 2'b10;
    localparam logic [1:0] DM_RSVD = 2'b11;

    // Widest lane count the helper supports (D_SIZE below 512 bits).
    localparam int DM_MAX_LANES = 64;

    typedef enum logic {
        DM_CLEAR = 1'b0,
        DM_IDLE  = 1'b1
    } dm_state_e;

    function automatic logic [DM_MAX_LANES-1:0] dm_byte_en(input logic [1:0] size,
                                                            input logic [5:0] off);
        logic [DM_MAX_LANES-1:0] mask;
        case (size)
            DM_BYTE: mask = DM_MAX_LANES'(4'b0001);
            DM_HALF: mask = DM_MAX_LANES'(4'b0011);
            DM_WORD: mask = DM_MAX_LANES'(4'b1111);
            default: mask = '0;
        endcase
        return mask << off;
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// Shifts the addressed bytes of a raw memory word down to bit 0 and sign- or
// zero-extends them to the full data width.
module dm_load_align
    import dm_pkg::*;
#(
    parameter int D_SIZE = 32,
    parameter int OFF_W  = 2
) (
    input  logic [D_SIZE-1:0] raw,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [D_SIZE-1:0] ext
);

    logic [D_SIZE-1:0] shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    assign shifted = raw >> {off, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];
    assign word_s  = shifted[31:0];

    always_comb begin
        ext = shifted;
        case (size)
            DM_BYTE: ext = is_unsigned ? D_SIZE'(shifted[7:0])  : D_SIZE'(byte_s);
            DM_HALF: ext = is_unsigned ? D_SIZE'(shifted[15:0]) : D_SIZE'(half_s);
            DM_WORD: ext = is_unsigned ? D_SIZE'(shifted[31:0]) : D_SIZE'(word_s);
            default: ext = shifted;
        endcase
    end

endmodule

// File: rtl/data_memory_be.sv
// MEM-stage data memory: byte/half/word stores with byte enables, registered
// extended loads, misalignment flagging and an optional post-reset zero-fill.
module data_memory_be
    import dm_pkg::*;
#(
    parameter int D_SIZE     = 32,
    parameter int AD_SIZE    = 32,
    parameter int DEPTH      = 32,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dm_memread,
    input  logic               dm_mem_write,
    input  logic [1:0]         dm_size,
    input  logic               dm_unsigned,
    input  logic [AD_SIZE-1:0] mem_address,
    input  logic [D_SIZE-1:0]  dm_data_input,
    output logic [D_SIZE-1:0]  dm_Memory_out_Data,
    output logic               dm_out_valid,
    output logic               dm_misaligned,
    output logic               dm_busy
);

    localparam int LANES = D_SIZE / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);

    logic [D_SIZE-1:0] mem_array [DEPTH];

    dm_state_e          state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [D_SIZE-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               misaligned_q, misaligned_d;

    logic [OFF_W-1:0]   off;
    logic [IDX_W-1:0]   idx;
    logic               misal;
    logic [LANES-1:0]   be;
    logic [DM_MAX_LANES-LANES-1:0] unused_be_hi;
    logic               unused_addr_hi;
    logic [D_SIZE-1:0]  load_ext;

    logic               we;
    logic [IDX_W-1:0]   w_idx;
    logic [LANES-1:0]   w_be;
    logic [D_SIZE-1:0]  w_data;

    assign off            = mem_address[OFF_W-1:0];
    assign idx            = mem_address[OFF_W+IDX_W-1:OFF_W];
    assign unused_addr_hi = ^mem_address[AD_SIZE-1:OFF_W+IDX_W];
    assign {unused_be_hi, be} = dm_byte_en(dm_size, 6'(off));

    always_comb begin
        case (dm_size)
            DM_BYTE: misal = 1'b0;
            DM_HALF: misal = off[0];
            DM_WORD: misal = |off;
            default: misal = 1'b1;
        endcase
    end

    dm_load_align #(
        .D_SIZE (D_SIZE),
        .OFF_W  (OFF_W)
    ) u_load_align (
        .raw         (mem_array[idx]),
        .off         (off),
        .size        (dm_size),
        .is_unsigned (dm_unsigned),
        .ext         (load_ext)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        misaligned_d = 1'b0;
        we           = 1'b0;
        w_idx        = idx;
        w_be         = be;
        w_data       = dm_data_input << {off, 3'b000};

        if (state_q == DM_CLEAR) begin
            // Requests are dropped entirely while the fill owns the write port.
            we     = 1'b1;
            w_idx  = cnt_q;
            w_be   = '1;
            w_data = '0;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = DM_IDLE;
            end
        end else if (dm_memread || dm_mem_write) begin
            if (misal) begin
                misaligned_d = 1'b1;
            end else if (dm_memread) begin
                out_data_d  = load_ext;
                out_valid_d = 1'b1;
            end else begin
                we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT_CLEAR ? DM_CLEAR : DM_IDLE;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_be[l]) begin
                    mem_array[w_idx][l*8 +: 8] <= w_data[l*8 +: 8];
                end
            end
        end
    end

    assign dm_Memory_out_Data = out_data_q;
    assign dm_out_valid       = out_valid_q;
    assign dm_misaligned      = misaligned_q;
    assign dm_busy            = (state_q == DM_CLEAR);

endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be: zero-fill timing, sized loads/stores,
// misalignment, read/write collision, busy behaviour and mid-fill reset.
module tb_data_memory_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm_memread;
    logic        dm_mem_write;
    logic [1:0]  dm_size;
    logic        dm_unsigned;
    logic [31:0] mem_address;
    logic [31:0] dm_data_input;
    logic [31:0] dm_Memory_out_Data;
    logic        dm_out_valid;
    logic        dm_misaligned;
    logic        dm_busy;

    int checks = 0;
    int errors = 0;

    data_memory_be #(
        .D_SIZE     (32),
        .AD_SIZE    (32),
        .DEPTH      (32),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .dm_memread         (dm_memread),
        .dm_mem_write       (dm_mem_write),
        .dm_size            (dm_size),
        .dm_unsigned        (dm_unsigned),
        .mem_address        (mem_address),
        .dm_data_input      (dm_data_input),
        .dm_Memory_out_Data (dm_Memory_out_Data),
        .dm_out_valid       (dm_out_valid),
        .dm_misaligned      (dm_misaligned),
        .dm_busy            (dm_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge, then sample 1 time unit later.
    task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] data);
        dm_memread    = rd;
        dm_mem_write  = wr;
        dm_size       = sz;
        dm_unsigned   = uns;
        mem_address   = addr;
        dm_data_input = data;
        @(posedge clk);
        #1;
        dm_memread   = 1'b0;
        dm_mem_write = 1'b0;
    endtask

    // Count edges until busy drops; a stray store to 0x0C is driven throughout.
    task automatic count_busy(input string tag, input int exp_cycles);
        int n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        while (dm_busy && n < 200) begin
            dm_mem_write  = 1'b1;
            dm_size       = 2'b10;
            mem_address   = 32'h0C;
            dm_data_input = 32'h0000_0055;
            @(posedge clk);
            #1;
            n++;
            if (dm_out_valid || dm_misaligned) bad = 1'b1;
        end
        dm_mem_write = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
        chk({tag, "_busy_quiet"}, {31'b0, bad}, 32'h0);
    endtask

    initial begin
        rst           = 1'b0;
        dm_memread    = 1'b0;
        dm_mem_write  = 1'b0;
        dm_size       = 2'b00;
        dm_unsigned   = 1'b0;
        mem_address   = '0;
        dm_data_input = '0;

        // 1: reset values and zero-fill duration
        #12;
        chk("rst_data", dm_Memory_out_Data, 32'h0);
        chk("rst_valid", {31'b0, dm_out_valid}, 32'h0);
        chk("rst_misal", {31'b0, dm_misaligned}, 32'h0);
        chk("rst_busy", {31'b0, dm_busy}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        count_busy("init", 32);
        req(1, 0, 2'b10, 0, 32'h00, 32'h0);
        chk("lw00_data", dm_Memory_out_Data, 32'h0);
        chk("lw00_valid", {31'b0, dm_out_valid}, 32'h1);
        req(1, 0, 2'b10, 0, 32'h7C, 32'h0);
        chk("lw7c_data", dm_Memory_out_Data, 32'h0);
        req(1, 0, 2'b10, 0, 32'h0C, 32'h0);
        chk("busy_sw_ignored", dm_Memory_out_Data, 32'h0);

        // 2: byte loads, signed and unsigned
        req(0, 1, 2'b10, 0, 32'h10, 32'h80FF_7F01);
        chk("sw10_valid", {31'b0, dm_out_valid}, 32'h0);
        req(1, 0, 2'b00, 0, 32'h10, 32'h0);
        chk("lb10", dm_Memory_out_Data, 32'h0000_0001);
        chk("lb10_valid", {31'b0, dm_out_valid}, 32'h1);
        req(1, 0, 2'b00, 0, 32'h11, 32'h0);
        chk("lb11", dm_Memory_out_Data, 32'h0000_007F);
        req(1, 0, 2'b00, 0, 32'h12, 32'h0);
        chk("lb12", dm_Memory_out_Data, 32'hFFFF_FFFF);
        req(1, 0, 2'b00, 0, 32'h13, 32'h0);
        chk("lb13", dm_Memory_out_Data, 32'hFFFF_FF80);
        req(1, 0, 2'b00, 1, 32'h12, 32'h0);
        chk("lbu12", dm_Memory_out_Data, 32'h0000_00FF);
        chk("lbu12_valid", {31'b0, dm_out_valid}, 32'h1);
        #10;
        chk("idle_valid_drop", {31'b0, dm_out_valid}, 32'h0);
        chk("idle_data_hold", dm_Memory_out_Data, 32'h0000_00FF);

        // 3: half store merges into word
        req(0, 1, 2'b10, 0, 32'h20, 32'h1122_3344);
        req(0, 1, 2'b01, 0, 32'h22, 32'h0000_BEEF);
        req(1, 0, 2'b10, 0, 32'h20, 32'h0);
        chk("lw20_merged", dm_Memory_out_Data, 32'hBEEF_3344);
        req(1, 0, 2'b01, 0, 32'h22, 32'h0);
        chk("lh22_signed", dm_Memory_out_Data, 32'hFFFF_BEEF);
        req(1, 0, 2'b01, 1, 32'h20, 32'h0);
        chk("lhu20", dm_Memory_out_Data, 32'h0000_3344);

        // 4: misaligned requests
        req(0, 1, 2'b10, 0, 32'h04, 32'hCAFE_F00D);
        req(1, 0, 2'b10, 0, 32'h06, 32'h0);
        chk("lw06_misal", {31'b0, dm_misaligned}, 32'h1);
        chk("lw06_valid", {31'b0, dm_out_valid}, 32'h0);
        req(0, 1, 2'b01, 0, 32'h05, 32'h0000_FFFF);
        chk("sh05_misal", {31'b0, dm_misaligned}, 32'h1);
        req(1, 0, 2'b11, 0, 32'h00, 32'h0);
        chk("rsvd_misal", {31'b0, dm_misaligned}, 32'h1);
        req(1, 0, 2'b10, 0, 32'h04, 32'h0);
        chk("lw04_unchanged", dm_Memory_out_Data, 32'hCAFE_F00D);
        chk("lw04_misal", {31'b0, dm_misaligned}, 32'h0);

        // 5: read and write together
        req(0, 1, 2'b10, 0, 32'h08, 32'h1234_5678);
        req(1, 1, 2'b10, 0, 32'h08, 32'h0000_DEAD);
        chk("rw08_data", dm_Memory_out_Data, 32'h1234_5678);
        chk("rw08_valid", {31'b0, dm_out_valid}, 32'h1);
        req(1, 0, 2'b10, 0, 32'h08, 32'h0);
        chk("lw08_after_rw", dm_Memory_out_Data, 32'h1234_5678);

        // 6: async reset, reset mid-fill, address aliasing
        chk("pre_rst_data", dm_Memory_out_Data, 32'h1234_5678);
        #2 rst = 1'b0;
        #1;
        chk("async_data", dm_Memory_out_Data, 32'h0);
        chk("async_valid", {31'b0, dm_out_valid}, 32'h0);
        chk("async_busy", {31'b0, dm_busy}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midfill_busy", {31'b0, dm_busy}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        count_busy("refill", 32);
        req(0, 1, 2'b10, 0, 32'h80, 32'h0000_A5A5);
        req(1, 0, 2'b10, 0, 32'h00, 32'h0);
        chk("alias80_00", dm_Memory_out_Data, 32'h0000_A5A5);
        req(1, 0, 2'b10, 0, 32'h20, 32'h0);
        chk("refill_zero20", dm_Memory_out_Data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
